text_cell_renderer: RTL
=======================

# text_cell_renderer

Parametrised character-cell renderer and the next generation of the keyboard-to-VGA text path. It accepts 7-bit ASCII codes over a valid/ready handshake and keeps a cursor on a COLS×ROWS grid. Each character becomes a stream of single-pixel writes to the `vga_adapter` (x, y, colour, plot). Over the first-generation renderer it adds configurable glyph and grid size, foreground and background colours, backspace, form-feed clear, and row wrap with clearing. Glyph bitmaps come from an external combinational glyph ROM.

## Interface
- GLYPH_W, 8, glyph width in pixels (power of 2)
- GLYPH_H, 16, glyph height in pixels (power of 2)
- COLS, 40, character columns
- ROWS, 15, character rows
- X_W, 9, x output width; COLS*GLYPH_W ≤ 2^X_W
- Y_W, 8, y output width; ROWS*GLYPH_H ≤ 2^Y_W
- COLOUR_W, 3, colour width
- clk  in  1  system clock (CLOCK_50 at top level)
- reset_n  in  1  reset; one clock, asynchronous, active-low
- char_valid  in  1  ascii holds a code
- char_ready  out  1  renderer can accept; high iff state is S_IDLE
- ascii  in  7  character code, sampled on accept
- fg_colour  in  COLOUR_W  colour for set glyph bits
- bg_colour  in  COLOUR_W  colour for clear bits and clears
- glyph_code  out  7  latched code, driven to the glyph ROM
- glyph_row  out  clog2(GLYPH_H)  current glyph row, driven to the ROM
- glyph_bits  in  GLYPH_W  ROM row data, combinational in the same cycle; MSB is the leftmost pixel
- x  out  X_W  pixel x (registered)
- y  out  Y_W  pixel y (registered)
- colour  out  COLOUR_W  pixel colour (registered)
- plot  out  1  write strobe to `vga_adapter` (registered)
- cursor_col  out  clog2(COLS)  current column
- cursor_row  out  clog2(ROWS)  current row

## Operation
- Reset values:
  - state S_IDLE
  - x = 0, y = 0, colour = 0, plot = 0
  - cursor at (0, 0)
  - glyph_code = 0
  - char_ready = 1 after reset release
- Accept occurs on a rising edge where char_valid && char_ready. On accept, ascii is latched into glyph_code and fg_colour/bg_colour are latched for the whole operation.
- States: S_IDLE, S_DRAW, S_ADV, S_BS_DRAW, S_CLR_ROW, S_CLR_ALL.
- Printable codes 0x20–0x7E: S_IDLE → S_DRAW → S_ADV.
  - S_DRAW walks the pixels of cell (cursor_col, cursor_row) row-major.
  - Each pixel is at x = cursor_col*GLYPH_W + px, y = cursor_row*GLYPH_H + py.
  - colour = glyph_bits[GLYPH_W-1-px] ? fg : bg.
- 0x0D (CR): S_IDLE → S_ADV as a newline; nothing is drawn.
- 0x08 (BS): the cursor first retreats.
  - col > 0: col−1.
  - col == 0 and row > 0: (COLS−1, row−1).
  - At (0, 0): no move.
  - Then S_BS_DRAW fills the new cell with bg; the cursor stays there. → S_IDLE.
- 0x0C (FF): S_CLR_ALL fills every pixel of the grid with bg, row-major. The cursor goes to (0, 0). → S_IDLE.
- Other codes are accepted and discarded: one cycle in S_ADV with no cursor change.
- S_ADV after a printable: col+1.
  - If col was COLS−1: col = 0, row+1.
  - If row was ROWS−1: row wraps to 0, then → S_CLR_ROW.
- S_ADV after CR: col = 0, row+1, with the same wrap rule.
- S_CLR_ROW fills all COLS*GLYPH_W*GLYPH_H pixels of the new row with bg, then → S_IDLE.
- No state reads from the framebuffer. Wrap-and-clear replaces true scrolling.
- Reset asserted mid-operation aborts immediately: plot = 0 and the cursor returns to (0, 0). Partially drawn pixels stay in the framebuffer.
- char_valid is ignored outside S_IDLE; the source must hold its code until accepted.

## Timing
- Accept edge E0.
- Edges E1..EN, with N = GLYPH_W*GLYPH_H: plot is registered high for pixel k−1 at edge Ek, so plot is high for exactly N consecutive cycles.
- E(N+1): state S_ADV, plot = 0, cursor updated. char_ready is high from E(N+2).
- Printable throughput is N+2 cycles per character: 130 at defaults.
- CR or discarded code: char_ready is low for 1 cycle.
- BS: retreat at E1, plot high for cycles E2..E(N+1).
- Row clear adds COLS*N plot cycles after S_ADV, plus 1 cycle.
- FF: COLS*ROWS*N plot cycles, plus 1 cycle.
- glyph_row and the px counter change on the same edge. ROM data must settle within one clock.
- Width rules:
  - Pixel counter width is clog2(N).
  - Coordinates are computed as col<<clog2(GLYPH_W) | px. No carries between the fields, since widths are powers of 2.

## Structure
- `text_defs.vh` holds the state encodings and the ASCII constants CR = 7'h0D, BS = 7'h08, FF = 7'h0C, plus the printable range bounds.
- Sub-module `cell_pixel_walker`: an enable/clear counter with last-pixel flag, emitting px, py, a cell index, and done. It is shared by S_DRAW, S_BS_DRAW, S_CLR_ROW and S_CLR_ALL; the clear depth is selected by a count-limit input.

## Test plan
- Reset, then 'A' (0x41) with fg = 3'b010, bg = 0 and a stub ROM:
  - Exactly 128 plots at x = 0..7, y = 0..15, in row-major order.
  - Colours match the ROM bits.
  - char_ready returns at accept + 130; cursor = (1, 0).
- 40 printables: the 41st draws at x = 0..7, y = 16..31; cursor = (1, 1).
- Cursor at (0, 14) receives CR:
  - Cursor goes to (0, 0).
  - 40*128 = 5120 bg plots covering y = 0..15.
  - char_ready returns afterwards.
- Cursor at (0, 1) receives BS: cursor = (39, 0) and 128 bg plots at x = 312..319, y = 0..15.
- FF: 76800 bg plots covering 320×240; cursor = (0, 0).
- Reset pulsed mid-glyph (pixel 50): plot drops asynchronously, cursor = (0, 0), char_ready = 1 after release.

Source files
------------

// File: rtl/text_cell_renderer_pkg.sv
// Shared state encodings, ASCII control codes and helpers for the text cell renderer.
package text_cell_renderer_pkg;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_DRAW    = 3'd1;
    localparam logic [2:0] S_ADV     = 3'd2;
    localparam logic [2:0] S_BS_DRAW = 3'd3;
    localparam logic [2:0] S_CLR_ROW = 3'd4;
    localparam logic [2:0] S_CLR_ALL = 3'd5;

    localparam logic [6:0] ASCII_BS          = 7'h08;
    localparam logic [6:0] ASCII_FF          = 7'h0C;
    localparam logic [6:0] ASCII_CR          = 7'h0D;
    localparam logic [6:0] ASCII_FIRST_PRINT = 7'h20;
    localparam logic [6:0] ASCII_LAST_PRINT  = 7'h7E;

    // What S_ADV should do with the cursor for the character just accepted.
    typedef enum logic [1:0] {
        OP_NONE,
        OP_PRINT,
        OP_NEWLINE
    } adv_op_t;

    function automatic logic is_printable(input logic [6:0] code);
        return (code >= ASCII_FIRST_PRINT) && (code <= ASCII_LAST_PRINT);
    endfunction

endpackage

// File: rtl/text_cell_renderer_walker.sv
// Pixel walker shared by every drawing state: walks glyph pixels row-major inside
// a cell, then steps across cells up to the given column/row limits.
module cell_pixel_walker #(
    parameter int GLYPH_W = 8,
    parameter int GLYPH_H = 16,
    parameter int COLS    = 40,
    parameter int ROWS    = 15
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         clear,
    input  logic                         enable,
    input  logic [$clog2(COLS)-1:0]      col_limit,
    input  logic [$clog2(ROWS)-1:0]      row_limit,
    output logic [$clog2(GLYPH_W)-1:0]   px,
    output logic [$clog2(GLYPH_H)-1:0]   py,
    output logic [$clog2(COLS)-1:0]      cell_col,
    output logic [$clog2(ROWS)-1:0]      cell_row,
    output logic                         last
);
    localparam int GW_B  = $clog2(GLYPH_W);
    localparam int PIX_B = $clog2(GLYPH_W * GLYPH_H);

    logic [PIX_B-1:0]        pix_reg;
    logic [$clog2(COLS)-1:0] col_reg;
    logic [$clog2(ROWS)-1:0] row_reg;
    logic                    pix_last;

    assign pix_last = &pix_reg;
    assign last     = pix_last && (col_reg == col_limit) && (row_reg == row_limit);
    assign px       = pix_reg[GW_B-1:0];
    assign py       = pix_reg[PIX_B-1:GW_B];
    assign cell_col = col_reg;
    assign cell_row = row_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pix_reg <= '0;
            col_reg <= '0;
            row_reg <= '0;
        end else if (clear) begin
            pix_reg <= '0;
            col_reg <= '0;
            row_reg <= '0;
        end else if (enable) begin
            pix_reg <= pix_reg + 1'b1;
            if (pix_last) begin
                if (col_reg == col_limit) begin
                    col_reg <= '0;
                    row_reg <= row_reg + 1'b1;
                end else begin
                    col_reg <= col_reg + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/text_cell_renderer.sv
// Character-cell renderer: turns accepted ASCII codes into single-pixel writes for
// the VGA adapter, tracking a cursor with wrap-and-clear, backspace and form feed.
module text_cell_renderer
    import text_cell_renderer_pkg::*;
#(
    parameter int GLYPH_W  = 8,
    parameter int GLYPH_H  = 16,
    parameter int COLS     = 40,
    parameter int ROWS     = 15,
    parameter int X_W      = 9,
    parameter int Y_W      = 8,
    parameter int COLOUR_W = 3
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        char_valid,
    output logic                        char_ready,
    input  logic [6:0]                  ascii,
    input  logic [COLOUR_W-1:0]         fg_colour,
    input  logic [COLOUR_W-1:0]         bg_colour,
    output logic [6:0]                  glyph_code,
    output logic [$clog2(GLYPH_H)-1:0]  glyph_row,
    input  logic [GLYPH_W-1:0]          glyph_bits,
    output logic [X_W-1:0]              x,
    output logic [Y_W-1:0]              y,
    output logic [COLOUR_W-1:0]         colour,
    output logic                        plot,
    output logic [$clog2(COLS)-1:0]     cursor_col,
    output logic [$clog2(ROWS)-1:0]     cursor_row
);
    localparam int GW_B  = $clog2(GLYPH_W);
    localparam int GH_B  = $clog2(GLYPH_H);
    localparam int COL_B = $clog2(COLS);
    localparam int ROW_B = $clog2(ROWS);

    logic [2:0]          state_reg;
    adv_op_t             op_reg;
    logic                bs_first_reg;
    logic [6:0]          code_reg;
    logic [COLOUR_W-1:0] fg_reg, bg_reg, colour_reg;
    logic [X_W-1:0]      x_reg;
    logic [Y_W-1:0]      y_reg;
    logic                plot_reg;
    logic [COL_B-1:0]    cursor_col_reg;
    logic [ROW_B-1:0]    cursor_row_reg;

    logic                walk_clear, walk_enable, walk_last;
    logic [COL_B-1:0]    walk_col_limit, walk_col;
    logic [ROW_B-1:0]    walk_row_limit, walk_row;
    logic [GW_B-1:0]     walk_px, bit_idx;
    logic [GH_B-1:0]     walk_py;
    logic [COL_B-1:0]    base_col;
    logic [ROW_B-1:0]    base_row;
    logic [X_W-1:0]      pix_x;
    logic [Y_W-1:0]      pix_y;
    logic [COLOUR_W-1:0] pix_colour;

    assign char_ready = (state_reg == S_IDLE);
    assign glyph_code = code_reg;
    assign glyph_row  = walk_py;
    assign x          = x_reg;
    assign y          = y_reg;
    assign colour     = colour_reg;
    assign plot       = plot_reg;
    assign cursor_col = cursor_col_reg;
    assign cursor_row = cursor_row_reg;

    // Walker sits at pixel 0 whenever it is not walking, so every pixel state starts clean.
    assign walk_clear  = (state_reg == S_IDLE) || (state_reg == S_ADV) ||
                         ((state_reg == S_BS_DRAW) && bs_first_reg);
    assign walk_enable = (state_reg == S_DRAW) || (state_reg == S_BS_DRAW) ||
                         (state_reg == S_CLR_ROW) || (state_reg == S_CLR_ALL);

    always_comb begin
        walk_col_limit = '0;
        walk_row_limit = '0;
        base_col       = cursor_col_reg;
        base_row       = cursor_row_reg;
        if (state_reg == S_CLR_ROW || state_reg == S_CLR_ALL) begin
            walk_col_limit = COL_B'(COLS - 1);
            base_col       = walk_col;
        end
        if (state_reg == S_CLR_ALL) begin
            walk_row_limit = ROW_B'(ROWS - 1);
            base_row       = walk_row;
        end
    end

    assign bit_idx    = GW_B'(GLYPH_W - 1) - walk_px;
    assign pix_x      = (X_W'(base_col) << GW_B) | X_W'(walk_px);
    assign pix_y      = (Y_W'(base_row) << GH_B) | Y_W'(walk_py);
    assign pix_colour = (state_reg == S_DRAW && glyph_bits[bit_idx]) ? fg_reg : bg_reg;

    cell_pixel_walker #(
        .GLYPH_W (GLYPH_W),
        .GLYPH_H (GLYPH_H),
        .COLS    (COLS),
        .ROWS    (ROWS)
    ) u_walker (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (walk_clear),
        .enable    (walk_enable),
        .col_limit (walk_col_limit),
        .row_limit (walk_row_limit),
        .px        (walk_px),
        .py        (walk_py),
        .cell_col  (walk_col),
        .cell_row  (walk_row),
        .last      (walk_last)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= S_IDLE;
            op_reg         <= OP_NONE;
            bs_first_reg   <= 1'b0;
            code_reg       <= '0;
            fg_reg         <= '0;
            bg_reg         <= '0;
            x_reg          <= '0;
            y_reg          <= '0;
            colour_reg     <= '0;
            plot_reg       <= 1'b0;
            cursor_col_reg <= '0;
            cursor_row_reg <= '0;
        end else begin
            plot_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (char_valid) begin
                        code_reg <= ascii;
                        fg_reg   <= fg_colour;
                        bg_reg   <= bg_colour;
                        op_reg   <= OP_NONE;
                        if (is_printable(ascii)) begin
                            op_reg    <= OP_PRINT;
                            state_reg <= S_DRAW;
                        end else if (ascii == ASCII_CR) begin
                            op_reg    <= OP_NEWLINE;
                            state_reg <= S_ADV;
                        end else if (ascii == ASCII_BS) begin
                            bs_first_reg <= 1'b1;
                            state_reg    <= S_BS_DRAW;
                        end else if (ascii == ASCII_FF) begin
                            state_reg <= S_CLR_ALL;
                        end else begin
                            state_reg <= S_ADV;
                        end
                    end
                end
                S_DRAW, S_CLR_ROW, S_CLR_ALL: begin
                    x_reg      <= pix_x;
                    y_reg      <= pix_y;
                    colour_reg <= pix_colour;
                    plot_reg   <= 1'b1;
                    if (walk_last) begin
                        state_reg <= (state_reg == S_DRAW) ? S_ADV : S_IDLE;
                        if (state_reg == S_CLR_ALL) begin
                            cursor_col_reg <= '0;
                            cursor_row_reg <= '0;
                        end
                    end
                end
                S_BS_DRAW: begin
                    if (bs_first_reg) begin
                        bs_first_reg <= 1'b0;
                        if (cursor_col_reg != '0) begin
                            cursor_col_reg <= cursor_col_reg - 1'b1;
                        end else if (cursor_row_reg != '0) begin
                            cursor_col_reg <= COL_B'(COLS - 1);
                            cursor_row_reg <= cursor_row_reg - 1'b1;
                        end
                    end else begin
                        x_reg      <= pix_x;
                        y_reg      <= pix_y;
                        colour_reg <= pix_colour;
                        plot_reg   <= 1'b1;
                        if (walk_last) state_reg <= S_IDLE;
                    end
                end
                S_ADV: begin
                    state_reg <= S_IDLE;
                    if (op_reg == OP_PRINT && cursor_col_reg != COL_B'(COLS - 1)) begin
                        cursor_col_reg <= cursor_col_reg + 1'b1;
                    end else if (op_reg != OP_NONE) begin
                        cursor_col_reg <= '0;
                        // Wrapping past the last row clears the row about to be reused.
                        if (cursor_row_reg == ROW_B'(ROWS - 1)) begin
                            cursor_row_reg <= '0;
                            state_reg      <= S_CLR_ROW;
                        end else begin
                            cursor_row_reg <= cursor_row_reg + 1'b1;
                        end
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

endmodule
